// File: rtl/obi_ram_bridge.sv
// OBI data-port bridge to the byte-enabled RAM port B, plus a small MMIO window
// for character print and simulation exit. Responses arrive one cycle after grant.
module obi_ram_bridge #(
  parameter int unsigned ADDR_WIDTH      = 18,
  parameter bit          STALL_EN        = 1'b0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter logic [31:0] PRINT_ADDR      = 32'h1000_0000,
  parameter logic [31:0] EXIT_VALUE_ADDR = 32'h2000_0000,
  parameter logic [31:0] EXIT_VALID_ADDR = 32'h2000_0004
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  output logic                  print_valid_o,
  output logic [7:0]            print_char_o,
  output logic                  exit_valid_o,
  output logic [31:0]           exit_value_o,
  output logic [7:0]            unmapped_cnt_o
);

  typedef enum logic [1:0] {
    SRC_RAM,
    SRC_MMIO,
    SRC_UNMAPPED
  } src_e;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] lfsr;
  logic        stall;
  logic        accept;
  logic        hit_ram;
  logic        hit_print;
  logic        hit_exit_value;
  logic        hit_exit_valid;
  logic        hit_mmio;
  logic        hit_unmapped;
  logic        rvalid_q;
  logic        we_q;
  src_e        src_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall      = STALL_EN && (lfsr[1:0] == 2'b00);
  assign data_gnt_o = data_req_i & ~stall & rst_ni;
  assign accept     = data_req_i & data_gnt_o;

  // RAM wins over MMIO, so MMIO hits are qualified by a RAM miss.
  assign hit_ram        = (data_addr_i >> ADDR_WIDTH) == 32'd0;
  assign hit_print      = !hit_ram && (data_addr_i == PRINT_ADDR);
  assign hit_exit_value = !hit_ram && (data_addr_i == EXIT_VALUE_ADDR);
  assign hit_exit_valid = !hit_ram && (data_addr_i == EXIT_VALID_ADDR);
  assign hit_mmio       = hit_print | hit_exit_value | hit_exit_valid;
  assign hit_unmapped   = !hit_ram && !hit_mmio;

  assign ram_en_o    = accept & hit_ram;
  assign ram_addr_o  = ram_en_o ? data_addr_i[ADDR_WIDTH-1:0] : '0;
  assign ram_we_o    = ram_en_o & data_we_i;
  assign ram_be_o    = ram_en_o ? data_be_i : 4'h0;
  assign ram_wdata_o = ram_en_o ? data_wdata_i : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      we_q     <= 1'b0;
      src_q    <= SRC_RAM;
    end else begin
      rvalid_q <= accept;
      we_q     <= data_we_i;
      if (hit_ram) begin
        src_q <= SRC_RAM;
      end else if (hit_mmio) begin
        src_q <= SRC_MMIO;
      end else begin
        src_q <= SRC_UNMAPPED;
      end
    end
  end

  assign data_rvalid_o = rvalid_q;

  always_comb begin
    data_rdata_o = 32'h0;
    if (rvalid_q && !we_q) begin
      case (src_q)
        SRC_RAM:      data_rdata_o = ram_rdata_i;
        SRC_UNMAPPED: data_rdata_o = 32'hDEAD_BEEF;
        default:      data_rdata_o = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      print_valid_o  <= 1'b0;
      print_char_o   <= 8'h00;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= 32'h0;
      unmapped_cnt_o <= 8'h00;
    end else begin
      print_valid_o <= accept && hit_print && data_we_i && data_be_i[0];
      if (accept && hit_print && data_we_i && data_be_i[0]) begin
        print_char_o <= data_wdata_i[7:0];
      end
      if (accept && hit_exit_value && data_we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (data_be_i[b]) begin
            exit_value_o[8*b +: 8] <= data_wdata_i[8*b +: 8];
          end
        end
      end
      if (accept && hit_exit_valid && data_we_i && data_be_i[0] && data_wdata_i[0]) begin
        exit_valid_o <= 1'b1;
      end
      if (accept && hit_unmapped && (unmapped_cnt_o != 8'hFF)) begin
        unmapped_cnt_o <= unmapped_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_obi_ram_bridge.sv
// Directed bench for obi_ram_bridge: a no-stall instance for functional vectors
// and a stalling instance checked against an LFSR and memory reference model.
module tb_obi_ram_bridge;

  localparam logic [31:0] PRINT_A = 32'h1000_0000;
  localparam logic [31:0] EXV_A   = 32'h2000_0000;
  localparam logic [31:0] EXT_A   = 32'h2000_0004;
  localparam logic [31:0] UNM_A   = 32'h3000_0000;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_n0, req0, we0, gnt0, rvalid0, ram_en0, ram_we0;
  logic [31:0] addr0, wdata0, rdata0, ram_wdata0, ram_rdata0, exit_value0;
  logic [3:0]  be0, ram_be0;
  logic [17:0] ram_addr0;
  logic        print_valid0, exit_valid0;
  logic [7:0]  print_char0, cnt0;

  logic        rst_n1, req1, we1, gnt1, rvalid1, ram_en1, ram_we1;
  logic [31:0] addr1, wdata1, rdata1, ram_wdata1, ram_rdata1, exit_value1;
  logic [3:0]  be1, ram_be1;
  logic [17:0] ram_addr1;
  logic        print_valid1, exit_valid1;
  logic [7:0]  print_char1, cnt1;

  obi_ram_bridge #(.STALL_EN(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n0), .data_req_i(req0), .data_gnt_o(gnt0),
    .data_addr_i(addr0), .data_we_i(we0), .data_be_i(be0), .data_wdata_i(wdata0),
    .data_rvalid_o(rvalid0), .data_rdata_o(rdata0), .ram_en_o(ram_en0),
    .ram_addr_o(ram_addr0), .ram_we_o(ram_we0), .ram_be_o(ram_be0),
    .ram_wdata_o(ram_wdata0), .ram_rdata_i(ram_rdata0), .print_valid_o(print_valid0),
    .print_char_o(print_char0), .exit_valid_o(exit_valid0), .exit_value_o(exit_value0),
    .unmapped_cnt_o(cnt0)
  );

  obi_ram_bridge #(.STALL_EN(1'b1)) dut_stall (
    .clk_i(clk), .rst_ni(rst_n1), .data_req_i(req1), .data_gnt_o(gnt1),
    .data_addr_i(addr1), .data_we_i(we1), .data_be_i(be1), .data_wdata_i(wdata1),
    .data_rvalid_o(rvalid1), .data_rdata_o(rdata1), .ram_en_o(ram_en1),
    .ram_addr_o(ram_addr1), .ram_we_o(ram_we1), .ram_be_o(ram_be1),
    .ram_wdata_o(ram_wdata1), .ram_rdata_i(ram_rdata1), .print_valid_o(print_valid1),
    .print_char_o(print_char1), .exit_valid_o(exit_valid1), .exit_value_o(exit_value1),
    .unmapped_cnt_o(cnt1)
  );

  // Behavioural port-B RAMs (1K words each, cleared on the first clock edge).
  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];
  logic        mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 1024; k++) begin
        mem0[k] <= 32'h0;
        mem1[k] <= 32'h0;
      end
      ram_rdata0 <= 32'h0;
      ram_rdata1 <= 32'h0;
      mem_ready  <= 1'b1;
    end else begin
      if (ram_en0) begin
        if (ram_we0) begin
          for (int b = 0; b < 4; b++)
            if (ram_be0[b]) mem0[ram_addr0[11:2]][8*b +: 8] <= ram_wdata0[8*b +: 8];
        end else begin
          ram_rdata0 <= mem0[ram_addr0[11:2]];
        end
      end
      if (ram_en1) begin
        if (ram_we1) begin
          for (int b = 0; b < 4; b++)
            if (ram_be1[b]) mem1[ram_addr1[11:2]][8*b +: 8] <= ram_wdata1[8*b +: 8];
        end else begin
          ram_rdata1 <= mem1[ram_addr1[11:2]];
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One complete transfer on the no-stall instance, entered and left just after a rising edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata);
    logic is_ram;
    is_ram = (addr < 32'h0004_0000);
    req0 = 1'b1; addr0 = addr; we0 = we; be0 = be; wdata0 = wdata;
    @(negedge clk);
    checkOutput("gnt", {31'd0, gnt0}, 32'd1);
    checkOutput("ram_en", {31'd0, ram_en0}, {31'd0, is_ram});
    if (is_ram) checkOutput("ram_addr", {14'd0, ram_addr0}, {14'd0, addr[17:0]});
    @(posedge clk); #1;
    req0 = 1'b0; addr0 = 32'h0; we0 = 1'b0; be0 = 4'h0; wdata0 = 32'h0;
    checkOutput("rvalid", {31'd0, rvalid0}, 32'd1);
    checkOutput("rdata", rdata0, exp_rdata);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  logic [31:0] ref_mem [0:1023];
  logic [15:0] lfsr_m;
  logic        hold, acc, exp_gnt, did_reset;
  logic [31:0] exp_rd;
  int          kind;

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    req0 = 1'b1; addr0 = 32'h100; we0 = 1'b0; be0 = 4'hF; wdata0 = 32'h0;
    req1 = 1'b0; addr1 = 32'h0; we1 = 1'b0; be1 = 4'h0; wdata1 = 32'h0;
    for (int k = 0; k < 1024; k++) ref_mem[k] = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_gnt", {31'd0, gnt0}, 32'd0);
    checkOutput("reset_rvalid", {31'd0, rvalid0}, 32'd0);
    checkOutput("reset_rdata", rdata0, 32'd0);
    checkOutput("reset_ram_en", {31'd0, ram_en0}, 32'd0);
    checkOutput("reset_ram_addr", {14'd0, ram_addr0}, 32'd0);
    checkOutput("reset_print_valid", {31'd0, print_valid0}, 32'd0);
    checkOutput("reset_exit_valid", {31'd0, exit_valid0}, 32'd0);
    checkOutput("reset_exit_value", exit_value0, 32'd0);
    checkOutput("reset_unmapped_cnt", {24'd0, cnt0}, 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0;
    rst_n0 = 1'b1;

    applyStimulus(32'h100, 1'b1, 4'hF, 32'h1234_5678, 32'h0);
    applyStimulus(32'h100, 1'b0, 4'hF, 32'h0, 32'h1234_5678);
    applyStimulus(32'h200, 1'b1, 4'hF, 32'h0, 32'h0);
    applyStimulus(32'h200, 1'b1, 4'b0010, 32'hAABB_CCDD, 32'h0);
    applyStimulus(32'h200, 1'b0, 4'hF, 32'h0, 32'h0000_CC00);
    applyStimulus(32'h3FFFC, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0);
    applyStimulus(32'h3FFFC, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D);

    applyStimulus(PRINT_A, 1'b1, 4'h1, 32'h0000_0041, 32'h0);
    checkOutput("print_valid_pulse", {31'd0, print_valid0}, 32'd1);
    checkOutput("print_char", {24'd0, print_char0}, 32'h41);
    @(posedge clk); #1;
    checkOutput("print_valid_drop", {31'd0, print_valid0}, 32'd0);
    applyStimulus(PRINT_A, 1'b0, 4'hF, 32'h0, 32'h0);

    applyStimulus(EXV_A, 1'b1, 4'hF, 32'h0000_0007, 32'h0);
    checkOutput("exit_value", exit_value0, 32'h7);
    checkOutput("exit_valid_early", {31'd0, exit_valid0}, 32'd0);
    applyStimulus(EXT_A, 1'b1, 4'h1, 32'h0000_0001, 32'h0);
    checkOutput("exit_valid_set", {31'd0, exit_valid0}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("exit_valid_held", {31'd0, exit_valid0}, 32'd1);
    checkOutput("exit_value_held", exit_value0, 32'h7);
    applyStimulus(EXV_A, 1'b0, 4'hF, 32'h0, 32'h0);

    for (int n = 0; n < 3; n++) applyStimulus(UNM_A, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF);
    checkOutput("unmapped_cnt_3", {24'd0, cnt0}, 32'd3);
    applyStimulus(32'h0004_0000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF);
    checkOutput("unmapped_cnt_boundary", {24'd0, cnt0}, 32'd4);
    for (int n = 0; n < 256; n++) applyStimulus(UNM_A, 1'b1, 4'hF, 32'h1, 32'h0);
    checkOutput("unmapped_cnt_sat", {24'd0, cnt0}, 32'hFF);

    req0 = 1'b1; addr0 = 32'h100; we0 = 1'b0; be0 = 4'hF;
    @(posedge clk); #1;
    req0 = 1'b0;
    checkOutput("midreset_rvalid_before", {31'd0, rvalid0}, 32'd1);
    rst_n0 = 1'b0;
    #1;
    checkOutput("midreset_rvalid_after", {31'd0, rvalid0}, 32'd0);
    checkOutput("midreset_exit_valid", {31'd0, exit_valid0}, 32'd0);
    checkOutput("midreset_cnt", {24'd0, cnt0}, 32'd0);
    @(posedge clk); #1;
    rst_n0 = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset_no_response", {31'd0, rvalid0}, 32'd0);

    // Stalling instance: random traffic against the LFSR and memory model.
    rst_n1 = 1'b1;
    lfsr_m = SEED;
    hold = 1'b0;
    acc = 1'b0;
    did_reset = 1'b0;
    exp_rd = 32'h0;
    for (int i = 0; i < 1000; i++) begin
      if (!hold) begin
        req1 = ($urandom_range(0, 9) < 8);
        kind = $urandom_range(0, 9);
        if (kind < 7)      addr1 = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
        else if (kind < 8) addr1 = PRINT_A;
        else if (kind < 9) addr1 = EXV_A;
        else               addr1 = UNM_A;
        we1 = 1'($urandom_range(0, 1));
        be1 = 4'($urandom_range(0, 15));
        wdata1 = $urandom;
      end
      exp_gnt = req1 && (lfsr_m[1:0] != 2'b00);
      @(negedge clk);
      checkOutput("stall_gnt", {31'd0, gnt1}, {31'd0, exp_gnt});
      if (exp_gnt) begin
        if (we1) begin
          exp_rd = 32'h0;
          if (addr1 < 32'h0004_0000)
            for (int b = 0; b < 4; b++)
              if (be1[b]) ref_mem[addr1[11:2]][8*b +: 8] = wdata1[8*b +: 8];
        end else if (addr1 < 32'h0004_0000) begin
          exp_rd = ref_mem[addr1[11:2]];
        end else if (addr1 == UNM_A) begin
          exp_rd = 32'hDEAD_BEEF;
        end else begin
          exp_rd = 32'h0;
        end
      end
      acc = exp_gnt;
      hold = req1 && !exp_gnt;
      @(posedge clk); #1;
      lfsr_m = lfsr_next(lfsr_m);
      checkOutput("stall_rvalid", {31'd0, rvalid1}, {31'd0, acc});
      if (acc) checkOutput("stall_rdata", rdata1, exp_rd);
      if (i >= 500 && !did_reset && acc) begin
        rst_n1 = 1'b0;
        #1;
        checkOutput("stall_async_rvalid", {31'd0, rvalid1}, 32'd0);
        checkOutput("stall_async_rdata", rdata1, 32'd0);
        @(posedge clk); #1;
        rst_n1 = 1'b1;
        lfsr_m = SEED;
        hold = 1'b0;
        did_reset = 1'b1;
      end
    end
    checkOutput("stall_reset_exercised", {31'd0, did_reset}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
